// File: rtl/ebike_pkg.sv
// Shared e-bike rider-effort definitions: widths, cadence thresholds and
// the torque averaging shift used by the sensor conditioning datapath.
package ebike_pkg;

  localparam int TORQUE_W   = 12;
  localparam int CAD_W      = 5;
  localparam int CAD_MIN    = 2;
  localparam int CAD_SAT    = 31;
  localparam int AVG_SHIFT  = 5;

  // Accumulator carries AVG_SHIFT fractional bits below the torque value.
  localparam int ACC_W      = TORQUE_W + AVG_SHIFT;
  // One spare bit above the cadence width so saturation is visible.
  localparam int EDGE_CNT_W = CAD_W + 1;

  typedef logic [TORQUE_W-1:0]   torque_t;
  typedef logic [CAD_W-1:0]      cadence_t;
  typedef logic [ACC_W-1:0]      accum_t;
  typedef logic [EDGE_CNT_W-1:0] edge_cnt_t;

endpackage

// File: rtl/pedal_sensor_cond_if.sv
// Sensor-side bundle of the pedal conditioning block: raw pedal pulse and
// torque sample in, conditioned rider-effort values out.
interface pedal_sensor_cond_if;
  import ebike_pkg::*;

  logic     cadence_raw;
  torque_t  torque;
  torque_t  avg_torque;
  cadence_t cadence;
  logic     not_pedaling;

  // Sensor front end / assist computation side.
  modport master (
    output cadence_raw,
    output torque,
    input  avg_torque,
    input  cadence,
    input  not_pedaling
  );

  // Conditioning block side.
  modport slave (
    input  cadence_raw,
    input  torque,
    output avg_torque,
    output cadence,
    output not_pedaling
  );

endinterface

// File: rtl/pedal_sensor_cond_cadence_debounce.sv
// Cadence pulse front end: two-flop synchronizer, optional stability filter
// and rising-edge detect of the accepted level.
// Build option: PEDAL_COND_DEBOUNCE_EN adds the stability filter; without it
// the accepted level is the synchronized level registered once.
module cadence_debounce
  import ebike_pkg::*;
#(
  parameter int STABLE_CYC = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cadence_raw_i,
  output logic cad_acc_o,
  output logic cad_edge_o
);

  if (STABLE_CYC < 1) begin : g_bad_cfg
    $error("cadence_debounce: STABLE_CYC must be at least 1");
  end

  logic sync1_q;
  logic sync2_q;
  logic acc_q, acc_d;
  logic acc_prev_q;

  // Stage: bring the asynchronous Hall pulse into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= cadence_raw_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef PEDAL_COND_DEBOUNCE_EN
  localparam int CNT_W = $clog2(STABLE_CYC + 1);

  logic [CNT_W-1:0] stab_q, stab_d;

  // Accept a new level only after it has differed from the held level
  // for STABLE_CYC consecutive cycles; any agreement restarts the count.
  always_comb begin
    acc_d  = acc_q;
    stab_d = '0;
    if (sync2_q != acc_q) begin
      if (stab_q == CNT_W'(STABLE_CYC)) begin
        acc_d  = sync2_q;
        stab_d = '0;
      end else begin
        stab_d = stab_q + 1'b1;
      end
    end
  end

  // Stability counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stab_q <= '0;
    end else begin
      stab_q <= stab_d;
    end
  end
`else
  // Without the filter the accepted level simply follows the synchronizer.
  always_comb begin
    acc_d = sync2_q;
  end
`endif

  // Stage: accepted level and its one-cycle history for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= 1'b0;
      acc_prev_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      acc_prev_q <= acc_q;
    end
  end

  assign cad_acc_o  = acc_q;
  assign cad_edge_o = acc_q & ~acc_prev_q;

endmodule

// File: rtl/pedal_sensor_cond.sv
// Pedal sensor conditioning: counts accepted cadence edges per fixed
// 2^WIN_W-cycle window and exponentially averages torque once per stroke.
// Build option: PEDAL_COND_DEBOUNCE_EN enables the cadence stability filter
// inside cadence_debounce.
module pedal_sensor_cond
  import ebike_pkg::*;
#(
  parameter int WIN_W      = 25,
  parameter int STABLE_CYC = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  pedal_sensor_cond_if.slave sns
);

  logic             cad_edge;
  logic [WIN_W-1:0] win_q, win_d;
  logic             win_tc;
  edge_cnt_t        edge_cnt_q, edge_cnt_d;
  cadence_t         cadence_q, cadence_d;
  logic             np_q, np_d;
  accum_t           accum_q, accum_d;

  // Clamp the window edge count to the reportable cadence range.
  function automatic cadence_t sat_cadence(input edge_cnt_t cnt);
    if (cnt > edge_cnt_t'(CAD_SAT)) begin
      return cadence_t'(CAD_SAT);
    end
    return cnt[CAD_W-1:0];
  endfunction

  // One EMA step with weight 1/32; the steady-state peak stays in range.
  function automatic accum_t ema_step(input accum_t acc, input torque_t smp);
    return acc - (acc >> AVG_SHIFT) + accum_t'(smp);
  endfunction

  // Restart the average directly at the current sample.
  function automatic accum_t ema_seed(input torque_t smp);
    return {smp, {AVG_SHIFT{1'b0}}};
  endfunction

  cadence_debounce #(
    .STABLE_CYC (STABLE_CYC)
  ) u_debounce (
    .clk           (clk),
    .rst_n         (rst_n),
    .cadence_raw_i (sns.cadence_raw),
    .cad_acc_o     (),
    .cad_edge_o    (cad_edge)
  );

  assign win_tc = &win_q;

  // Window counting: edges accumulate until terminal count, then the count
  // is published and restarted; an edge on the terminal cycle opens the
  // new window with a count of one.
  always_comb begin
    win_d      = win_q + 1'b1;
    edge_cnt_d = edge_cnt_q;
    cadence_d  = cadence_q;
    np_d       = np_q;
    if (cad_edge && (edge_cnt_q < edge_cnt_t'(CAD_SAT))) begin
      edge_cnt_d = edge_cnt_q + 1'b1;
    end
    if (win_tc) begin
      cadence_d  = sat_cadence(edge_cnt_q);
      np_d       = (edge_cnt_q < edge_cnt_t'(CAD_MIN));
      edge_cnt_d = cad_edge ? edge_cnt_t'(1) : edge_cnt_t'(0);
    end
  end

  // Torque average: advance once per stroke, re-seeding when the rider was
  // idle during the last reported window; otherwise hold.
  always_comb begin
    accum_d = accum_q;
    if (cad_edge) begin
      accum_d = np_q ? ema_seed(sns.torque) : ema_step(accum_q, sns.torque);
    end
  end

  // Stage: window counter, edge count and published cadence state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q      <= '0;
      edge_cnt_q <= '0;
      cadence_q  <= '0;
      np_q       <= 1'b1;
    end else begin
      win_q      <= win_d;
      edge_cnt_q <= edge_cnt_d;
      cadence_q  <= cadence_d;
      np_q       <= np_d;
    end
  end

  // Stage: torque accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accum_q <= '0;
    end else begin
      accum_q <= accum_d;
    end
  end

  assign sns.avg_torque   = accum_q[ACC_W-1:AVG_SHIFT];
  assign sns.cadence      = cadence_q;
  assign sns.not_pedaling = np_q;

endmodule

// File: tb/tb_pedal_sensor_cond.sv
// Self-checking bench for pedal_sensor_cond with a short window and short
// stability filter; expectations come from a window/stroke level model.
`timescale 1ns/1ps
module tb_pedal_sensor_cond;
  import ebike_pkg::*;

  localparam int WIN_W      = 10;
  localparam int STABLE_CYC = 4;
  localparam int WIN_LEN    = 1 << WIN_W;
`ifdef PEDAL_COND_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
`else
  localparam bit DEB = 1'b0;
`endif
  // Cycles from the first clock edge that samples a raw rise to the clock
  // edge that consumes the resulting cadence edge.
  localparam int LAT = DEB ? (3 + STABLE_CYC) : 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pedal_sensor_cond_if sns ();

  pedal_sensor_cond #(
    .WIN_W      (WIN_W),
    .STABLE_CYC (STABLE_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sns   (sns)
  );

  always #5 clk = ~clk;

  int edge_no = 0;
  int base    = 0;
  bit mon_en  = 1'b0;
  int n_cmp   = 0;
  int n_err   = 0;

  always @(posedge clk) edge_no <= edge_no + 1;

  // Model state: accepted edges per window, and torque average history.
  int win_cnt [int];
  int hist_d  [$];
  int hist_v  [$];
  int acc_m   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int now_n();
    return edge_no - base - 1;
  endfunction

  function automatic int cnt_of(input int w);
    return win_cnt.exists(w) ? win_cnt[w] : 0;
  endfunction

  // not_pedaling as last published before clock edge d.
  function automatic bit np_before(input int d);
    int b, pw;
    b  = (d + 1) / WIN_LEN;
    pw = (d == b * WIN_LEN - 1) ? b - 2 : b - 1;
    if (pw < 0) return 1'b1;
    return cnt_of(pw) < CAD_MIN;
  endfunction

  function automatic int acc_at(input int t);
    for (int i = hist_d.size() - 1; i >= 0; i--) begin
      if (hist_d[i] <= t) return hist_v[i];
    end
    return 0;
  endfunction

  task automatic wait_until(input int target);
    while (now_n() < target) begin
      @(posedge clk); #1;
    end
  endtask

  // One raw pulse: h cycles high then l cycles low, torque held at t.
  task automatic pulse(input int h, input int l, input int t, input bit clean);
    int  k, d, w;
    bit  prod;
    @(posedge clk); #1;
    k = now_n();
    sns.cadence_raw = 1'b1;
    sns.torque      = torque_t'(t);
    prod = clean || !DEB;
    d    = k + 1 + LAT;
    if (prod) begin
      w = (d + 1) / WIN_LEN;
      if (np_before(d)) acc_m = t << AVG_SHIFT;
      else              acc_m = acc_m - (acc_m >> AVG_SHIFT) + t;
      win_cnt[w] = cnt_of(w) + 1;
      hist_d.push_back(d);
      hist_v.push_back(acc_m);
    end
    for (int i = 0; i < h + l; i++) begin
      @(posedge clk); #1;
      if (i == h - 1) sns.cadence_raw = 1'b0;
      if (prod && now_n() == d) check("avg_on_edge", sns.avg_torque, acc_m >> AVG_SHIFT);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n  = 1'b0;
    mon_en = 1'b0;
    #1;
    check("rst_avg", sns.avg_torque, 0);
    check("rst_cadence", sns.cadence, 0);
    check("rst_np", sns.not_pedaling, 1);
    repeat (3) @(posedge clk);
    #1;
    win_cnt.delete();
    hist_d.delete();
    hist_v.delete();
    acc_m  = 0;
    rst_n  = 1'b1;
    base   = edge_no;
    mon_en = 1'b1;
  endtask

  // Window-end checks, sampled on the falling edge after terminal count.
  always @(negedge clk) begin
    int n, w, c;
    if (rst_n && mon_en) begin
      n = now_n();
      if (n >= 0 && (n % WIN_LEN) == WIN_LEN - 1) begin
        w = n / WIN_LEN;
        c = cnt_of(w);
        check($sformatf("cadence_win%0d", w), sns.cadence, (c > CAD_SAT) ? CAD_SAT : c);
        check($sformatf("np_win%0d", w), sns.not_pedaling, (c < CAD_MIN) ? 1 : 0);
        check($sformatf("avg_win%0d", w), sns.avg_torque, acc_at(n) >> AVG_SHIFT);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, observed %0d compares, required completion", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int tc, k;
    sns.cadence_raw = 1'b0;
    sns.torque      = '0;
    do_reset();

    // Window 0: seed on first stroke, then 8 clean strokes at constant torque.
    wait_until(5);
    pulse(20, 40, 'h800, 1'b1);
    check("avg_seed", sns.avg_torque, 'h800);
    for (int i = 0; i < 7; i++) pulse(20, 40, 'h800, 1'b1);

    // Window 1: first stroke after pedaling window, then saturate at 40.
    wait_until(WIN_LEN + 5);
    pulse(8, 12, 'hA00, 1'b1);
    check("avg_a00", sns.avg_torque, 'h810);
    for (int i = 0; i < 39; i++) pulse(8, 12, $urandom_range(0, 4095), 1'b1);

    // Window 2: single stroke -> idle.
    wait_until(2 * WIN_LEN + 5);
    pulse(20, 40, $urandom_range(0, 4095), 1'b1);

    // Window 3: random mix of clean strokes and short glitches.
    wait_until(3 * WIN_LEN + 5);
    pulse(2, 20, $urandom_range(0, 4095), 1'b0);
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 2) == 0)
        pulse($urandom_range(1, STABLE_CYC - 1), $urandom_range(STABLE_CYC + 3, 20),
              $urandom_range(0, 4095), 1'b0);
      else
        pulse($urandom_range(STABLE_CYC + 3, 20), $urandom_range(STABLE_CYC + 3, 30),
              $urandom_range(0, 4095), 1'b1);
    end

    // Window 4/5: one stroke, then one landing exactly on terminal count.
    wait_until(4 * WIN_LEN + 5);
    pulse(20, 40, $urandom_range(0, 4095), 1'b1);
    tc = 5 * WIN_LEN - 1;
    k  = tc - 1 - LAT;
    wait_until(k - 1);
    pulse(20, 40, $urandom_range(0, 4095), 1'b1);
    pulse(20, 40, $urandom_range(0, 4095), 1'b1);
    pulse(20, 40, $urandom_range(0, 4095), 1'b1);

    // Window 6: partial activity, then reset mid-window.
    wait_until(6 * WIN_LEN + 5);
    pulse(20, 40, $urandom_range(0, 4095), 1'b1);
    pulse(20, 40, $urandom_range(0, 4095), 1'b1);
    do_reset();

    // First window after reset counts only post-reset strokes.
    wait_until(5);
    for (int i = 0; i < 3; i++) pulse(20, 40, $urandom_range(0, 4095), 1'b1);
    wait_until(WIN_LEN + 2);
    check("post_rst_cadence", sns.cadence, 3);
    check("post_rst_np", sns.not_pedaling, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pedal_sensor_cond.md
# pedal_sensor_cond

Conditions the raw pedal-cadence pulse and torque-sensor sample into the three rider-effort inputs consumed by the assist-current calculation: `avg_torque`, `cadence` and `not_pedaling`. It sits between the sensor front end (pedal Hall pulse, torque ADC result) and the assist computation. It synchronizes and filters the cadence pulse, counts pulses per fixed window and exponentially averages torque on each pedal stroke. All outputs are registered and update at defined events only.

## Interface
- `WIN_W`, default 25: window length is 2^WIN_W clk cycles (≈0.67 s at 50 MHz).
- `STABLE_CYC`, default 1024: consecutive cycles a new cadence level must hold before it is accepted.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cadence_raw`  in  1  pedal Hall sensor pulse; asynchronous to `clk`.
- `torque`  in  12  latest unsigned torque sample, valid every cycle.
- `avg_torque`  out  12  exponentially averaged torque.
- `cadence`  out  5  rising edges per window, saturated at 31.
- `not_pedaling`  out  1  high when the last window count is below `CAD_MIN` (2).

## Operation
- **Synchronizer:** two flops on `cadence_raw` (reset 0) give `cad_sync`.
- **Filter:** `cad_acc` holds the accepted level (reset 0). A stability counter increments while `cad_sync != cad_acc` and clears when they are equal. When the counter reaches `STABLE_CYC`, `cad_acc` takes `cad_sync` and the counter clears. `cad_edge` is a one-cycle pulse on each 0→1 transition of `cad_acc`.
- **Window:** a free-running `WIN_W`-bit counter, reset 0. `edge_cnt` is 6 bits, increments per `cad_edge` and saturates at 31. At terminal count (all ones):
  - `cadence` <= min(edge_cnt, 31)
  - `not_pedaling` <= (edge_cnt < 2)
  - `edge_cnt` <= `cad_edge` ? 1 : 0. An edge coincident with terminal count belongs to the new window.
- **Torque average:** 17-bit unsigned accumulator `accum`, reset 0. On `cad_edge`:
  - if `not_pedaling`=1: seed, `accum` <= {torque, 5'b0}
  - else: `accum` <= accum − (accum>>5) + torque

  `avg_torque` = accum[16:5] and is a direct slice, so it introduces no extra register stage. The accumulator cannot overflow: its steady-state maximum is 0x1FFE0.
- `avg_torque` and `accum` hold between edges. The torque average is not cleared when `not_pedaling` rises; instead the next stroke re-seeds it.

## Timing
- **Reset values:** `avg_torque`=0, `cadence`=0, `not_pedaling`=1. All internal counters are 0.
- **Raw edge to `cad_edge`:** 2 sync cycles + `STABLE_CYC` cycles + 1 cycle.
- **`cad_edge` to `avg_torque`:** `avg_torque` changes the following cycle.
- **`cadence` and `not_pedaling`:** both update together, one cycle after the terminal count. Latency from the last stroke can therefore reach 2^WIN_W cycles.
- **Glitches:** a pulse shorter than `STABLE_CYC` cycles never changes `cad_acc`.
- **Reset mid-window:** reset discards the partial count. The first full window after reset produces the first valid `cadence`.

## Configuration
- Macro `PEDAL_COND_DEBOUNCE_EN`.
- **Defined:** the stability filter is present as described above.
- **Undefined:** `cad_acc` = `cad_sync` registered once, giving raw edge to `cad_edge` in 3 cycles. `STABLE_CYC` is ignored and no stability counter is synthesized.

## Structure
- Shared package `ebike_pkg` holds:
  - `TORQUE_W`=12 and `CAD_W`=5
  - `CAD_MIN`=2 and `CAD_SAT`=31
  - `AVG_SHIFT`=5
  - the typedefs `torque_t` (logic [11:0]) and `cadence_t` (logic [4:0])
- One sub-module, `cadence_debounce`: synchronizer, stability filter and edge detect. It has outputs `cad_acc` and `cad_edge`, and is where the configuration macro is applied. Window counting and averaging stay in the top module.

## Test plan
All scenarios run with `WIN_W`=10 and `STABLE_CYC`=4.
- **Reset:** assert `rst_n`=0 mid-window → `avg_torque`=0, `cadence`=0, `not_pedaling`=1 immediately; after release, the first window end reports the count of post-reset edges only.
- **Normal cadence:** 8 clean pulses (20 high / 40 low cycles) in one window → at window end `cadence`=8 and `not_pedaling`=0.
- **Saturation and idle:**
  - 40 clean pulses in a window → `cadence`=31.
  - A following window with 1 pulse → `cadence`=1 and `not_pedaling`=1.
- **Glitch rejection:** a 2-cycle high glitch → not counted with `PEDAL_COND_DEBOUNCE_EN` defined; counted as 1 edge with it undefined.
- **Averaging:**
  - While `not_pedaling`=1, an edge with `torque`=0x800 → `avg_torque`=0x800.
  - After a pedaling window, an edge with `torque`=0xA00 → `avg_torque`=0x810.
- **Coincident edge:** `cad_edge` on the terminal-count cycle → counted in the new window (`edge_cnt`=1), not the closing window.
